// File: rtl/wb_la_initiator_if.sv
// rtl/wb_la_initiator_if.sv - command/response handshakes and Wishbone classic bus of wb_la_initiator
interface wb_la_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_la_initiator.sv
// rtl/wb_la_initiator.sv - Wishbone classic initiator, one bus cycle per command/response handshake
// Optional bus timeout enabled by defining WB_TIMEOUT_EN.
module wb_la_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_la_initiator_if.master bus,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;
  logic   timeout_hit;

  // Bus addresses are word aligned, so the byte offset is dropped.
  logic [1:0] adr_lsb_unused;
  assign adr_lsb_unused = bus.cmd_adr[1:0];

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  // Terminal cycle: the count would reach TIMEOUT_CYCLES at this edge.
  assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dat   <= '0;
      bus.rsp_err   <= 1'b0;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_sel_o <= '0;
      bus.wbm_adr_o <= '0;
      bus.wbm_dat_o <= '0;
      busy_o        <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.wbm_adr_o <= {bus.cmd_adr[31:2], 2'b00};
            bus.wbm_we_o  <= bus.cmd_we;
            bus.wbm_sel_o <= bus.cmd_sel;
            bus.wbm_dat_o <= bus.cmd_we ? bus.cmd_dat : 32'h0;
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            bus.cmd_ready <= 1'b0;
            busy_o        <= 1'b1;
            state         <= BUS;
`ifdef WB_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        BUS: begin
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_dat   <= bus.wbm_we_o ? 32'h0 : bus.wbm_dat_i;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (timeout_hit) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_dat   <= ERR_DATA;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
`ifdef WB_TIMEOUT_EN
            tmo_cnt       <= tmo_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy_o        <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.wbm_cyc_o <= 1'b0;
          bus.wbm_stb_o <= 1'b0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_la_initiator.sv
// tb/tb_wb_la_initiator.sv - directed self-checking bench for wb_la_initiator
module tb_wb_la_initiator;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  wb_la_initiator_if bus_if ();

  wb_la_initiator #(
    .TIMEOUT_CYCLES(4),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus_if),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = we;
    bus_if.cmd_sel   = 4'hF;
    bus_if.cmd_adr   = adr;
    bus_if.cmd_dat   = dat;
    step();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic consume();
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_sel   = 4'h0;
    bus_if.cmd_adr   = 32'h0;
    bus_if.cmd_dat   = 32'h0;
    bus_if.rsp_ready = 1'b0;
    bus_if.wbm_dat_i = 32'h0;
    bus_if.wbm_ack_i = 1'b0;
    step();
    step();
    check("rst_cmd_ready", bus_if.cmd_ready, 1);
    check("rst_rsp_valid", bus_if.rsp_valid, 0);
    check("rst_cyc", bus_if.wbm_cyc_o, 0);
    check("rst_stb", bus_if.wbm_stb_o, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_dat", bus_if.rsp_dat, 0);
    check("rst_rsp_err", bus_if.rsp_err, 0);
    check("rst_adr", bus_if.wbm_adr_o, 0);
    rst = 1'b0;
    step();

    // Write with two wait cycles: cyc/stb high for exactly three cycles.
    issue(1'b1, 32'h3000_0005, 32'h0000_00A5);
    check("wr_c1_cyc", bus_if.wbm_cyc_o, 1);
    check("wr_c1_stb", bus_if.wbm_stb_o, 1);
    check("wr_adr", bus_if.wbm_adr_o, 32'h3000_0004);
    check("wr_dat", bus_if.wbm_dat_o, 32'h0000_00A5);
    check("wr_we", bus_if.wbm_we_o, 1);
    check("wr_sel", bus_if.wbm_sel_o, 4'hF);
    check("wr_cmd_ready", bus_if.cmd_ready, 0);
    check("wr_busy", busy, 1);
    step();
    check("wr_c2_cyc", bus_if.wbm_cyc_o, 1);
    step();
    check("wr_c3_cyc", bus_if.wbm_cyc_o, 1);
    check("wr_c3_rsp_valid", bus_if.rsp_valid, 0);
    bus_if.wbm_ack_i = 1'b1;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("wr_done_cyc", bus_if.wbm_cyc_o, 0);
    check("wr_done_stb", bus_if.wbm_stb_o, 0);
    check("wr_rsp_valid", bus_if.rsp_valid, 1);
    check("wr_rsp_dat", bus_if.rsp_dat, 0);
    check("wr_rsp_err", bus_if.rsp_err, 0);
    check("wr_hold_adr", bus_if.wbm_adr_o, 32'h3000_0004);
    consume();
    check("wr_after_rsp_valid", bus_if.rsp_valid, 0);
    check("wr_after_cmd_ready", bus_if.cmd_ready, 1);
    check("wr_after_busy", busy, 0);

    // Zero-wait read: rsp_valid two cycles after the handshake cycle.
    issue(1'b0, 32'h3000_0000, 32'hDEAD_BEEF);
    check("rd_cyc", bus_if.wbm_cyc_o, 1);
    check("rd_dat_o", bus_if.wbm_dat_o, 0);
    check("rd_we", bus_if.wbm_we_o, 0);
    check("rd_early_rsp_valid", bus_if.rsp_valid, 0);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'h1234_5678;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("rd_rsp_valid", bus_if.rsp_valid, 1);
    check("rd_rsp_dat", bus_if.rsp_dat, 32'h1234_5678);
    check("rd_cyc_low", bus_if.wbm_cyc_o, 0);

    // Backpressure with a pending command and stray acks while in RESP.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = 1'b1;
    bus_if.cmd_adr   = 32'h3000_0010;
    bus_if.cmd_dat   = 32'h0000_0055;
    bus_if.wbm_dat_i = 32'hAAAA_AAAA;
    for (int i = 0; i < 10; i++) begin
      bus_if.wbm_ack_i = (i % 3 == 1);
      step();
      check("bp_rsp_valid", bus_if.rsp_valid, 1);
      check("bp_rsp_dat", bus_if.rsp_dat, 32'h1234_5678);
      check("bp_cmd_ready", bus_if.cmd_ready, 0);
      check("bp_cyc", bus_if.wbm_cyc_o, 0);
    end
    bus_if.wbm_ack_i = 1'b0;
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.rsp_ready = 1'b0;
    check("bp_rel_rsp_valid", bus_if.rsp_valid, 0);
    check("bp_rel_cmd_ready", bus_if.cmd_ready, 1);
    check("bp_rel_cyc", bus_if.wbm_cyc_o, 0);
    step();
    bus_if.cmd_valid = 1'b0;
    check("bp_new_cyc", bus_if.wbm_cyc_o, 1);
    check("bp_new_adr", bus_if.wbm_adr_o, 32'h3000_0010);
    check("bp_new_dat", bus_if.wbm_dat_o, 32'h0000_0055);
    bus_if.wbm_ack_i = 1'b1;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("bp_new_rsp_valid", bus_if.rsp_valid, 1);
    check("bp_new_rsp_dat", bus_if.rsp_dat, 0);
    consume();

    // Stray acks in IDLE leave the last read data untouched.
    issue(1'b0, 32'h3000_0008, 32'h0);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'hCAFE_F00D;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("rd2_rsp_dat", bus_if.rsp_dat, 32'hCAFE_F00D);
    consume();
    bus_if.wbm_dat_i = 32'hAAAA_AAAA;
    for (int i = 0; i < 3; i++) begin
      bus_if.wbm_ack_i = 1'b1;
      step();
      check("idle_stray_cyc", bus_if.wbm_cyc_o, 0);
      check("idle_stray_busy", busy, 0);
      check("idle_stray_rsp_valid", bus_if.rsp_valid, 0);
      check("idle_stray_rsp_dat", bus_if.rsp_dat, 32'hCAFE_F00D);
    end
    bus_if.wbm_ack_i = 1'b0;

`ifdef WB_TIMEOUT_EN
    // No ack: four BUS cycles, then an error response.
    issue(1'b0, 32'h3000_0020, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("tmo_cyc_high", bus_if.wbm_cyc_o, 1);
      step();
    end
    check("tmo_cyc_low", bus_if.wbm_cyc_o, 0);
    check("tmo_rsp_valid", bus_if.rsp_valid, 1);
    check("tmo_rsp_err", bus_if.rsp_err, 1);
    check("tmo_rsp_dat", bus_if.rsp_dat, 32'hFFFF_FFFF);
    consume();
    // Ack on the terminal cycle beats the timeout.
    issue(1'b0, 32'h3000_0024, 32'h0);
    for (int i = 0; i < 3; i++) step();
    check("tmo_ack_c4_cyc", bus_if.wbm_cyc_o, 1);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'h0BAD_CAFE;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("tmo_ack_rsp_valid", bus_if.rsp_valid, 1);
    check("tmo_ack_rsp_err", bus_if.rsp_err, 0);
    check("tmo_ack_rsp_dat", bus_if.rsp_dat, 32'h0BAD_CAFE);
    consume();
`endif

    // Reset while the bus cycle is open aborts without a response.
    issue(1'b1, 32'h3000_0030, 32'h0000_0011);
    check("rstbus_pre_cyc", bus_if.wbm_cyc_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstbus_cyc", bus_if.wbm_cyc_o, 0);
    check("rstbus_stb", bus_if.wbm_stb_o, 0);
    check("rstbus_rsp_valid", bus_if.rsp_valid, 0);
    check("rstbus_cmd_ready", bus_if.cmd_ready, 1);
    check("rstbus_busy", busy, 0);
    bus_if.wbm_ack_i = 1'b1;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("rstbus_no_rsp", bus_if.rsp_valid, 0);
    check("rstbus_no_cyc", bus_if.wbm_cyc_o, 0);

    // Reset while a response is pending discards it.
    issue(1'b0, 32'h3000_0034, 32'h0);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'h5555_0000;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("rstresp_pre_valid", bus_if.rsp_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstresp_rsp_valid", bus_if.rsp_valid, 0);
    check("rstresp_cmd_ready", bus_if.cmd_ready, 1);
    check("rstresp_cyc", bus_if.wbm_cyc_o, 0);

    // Normal transaction after the resets.
    issue(1'b0, 32'h3000_000E, 32'h0);
    check("post_adr", bus_if.wbm_adr_o, 32'h3000_000C);
    step();
    check("post_wait_cyc", bus_if.wbm_cyc_o, 1);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'h600D_D00D;
    step();
    bus_if.wbm_ack_i = 1'b0;
    check("post_rsp_valid", bus_if.rsp_valid, 1);
    check("post_rsp_dat", bus_if.rsp_dat, 32'h600D_D00D);
    check("post_rsp_err", bus_if.rsp_err, 0);
    consume();
    check("post_idle_cmd_ready", bus_if.cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_la_initiator.md
Name: wb_la_initiator

Overview:
- Wishbone classic initiator (master) that turns single-word command/response handshakes into one bus cycle each.
- It is the initiator counterpart to the user-area Wishbone responders.
- Bring-up use: the command side is driven from logic-analyzer/GPIO-sourced registers, so the ring-oscillator mux registers can be exercised without the management SoC.
- Runs on the Wishbone clock domain.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles a bus cycle may stay open awaiting ack (>=1); only used when WB_TIMEOUT_EN is defined.
- ERR_DATA, 32'hFFFF_FFFF, value returned on rsp_dat on timeout.

Ports:
- wb_clk_i  input  1  clock.
- wb_rst_i  input  1  reset; synchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_we  input  1  1=write, 0=read.
- cmd_sel  input  4  byte enables.
- cmd_adr  input  32  byte address.
- cmd_dat  input  32  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_dat  output  32  read data, 0 for writes, ERR_DATA on timeout.
- rsp_err  output  1  1 = timeout, qualified by rsp_valid.
- busy_o  output  1  state != IDLE.
- wbm_cyc_o  output  1  Wishbone CYC.
- wbm_stb_o  output  1  Wishbone STB.
- wbm_we_o  output  1  Wishbone WE.
- wbm_sel_o  output  4  Wishbone SEL.
- wbm_adr_o  output  32  Wishbone ADR, word aligned.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_dat_i  input  32  Wishbone read data.
- wbm_ack_i  input  1  Wishbone ACK.

Behaviour:
- Reset values (at the edge where wb_rst_i is sampled high): state=IDLE; all outputs 0 except cmd_ready=1; timeout counter cleared.
- States: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&cmd_ready, register the command: wbm_adr_o={cmd_adr[31:2],2'b00}, wbm_we_o, wbm_sel_o, wbm_dat_o (forced 0 for reads).
  - Go to BUS. wbm_cyc_o/wbm_stb_o go high the following cycle (1-cycle latency from handshake).
- BUS:
  - cyc=stb=1; cmd_ready=0; address/data/sel/we held stable.
  - On an edge with wbm_ack_i=1: drop cyc/stb, capture wbm_dat_i into rsp_dat (reads) or 0 (writes), rsp_err=0, rsp_valid=1, go to RESP.
  - Ack takes effect one cycle after assertion. Minimum command-to-response: handshake edge, BUS entry, ack edge → rsp_valid visible 2 cycles after handshake with zero-wait slave.
- RESP:
  - rsp_valid=1 with rsp_dat/rsp_err stable until an edge with rsp_ready=1, then IDLE with rsp_valid=0.
  - cmd_ready stays 0 until IDLE is reached: no pipelining, one outstanding transaction.
- Stray ack: wbm_ack_i in IDLE or RESP is ignored, with no state or data change.
- Wishbone outputs: wbm_we/sel/adr/dat_o hold their last value outside BUS. Only cyc/stb are guaranteed 0 there.
- Reset mid-operation: from any state, sync reset returns to IDLE at that edge. cyc/stb low from that edge, any pending response is discarded, and no response is produced for the aborted command.
- busy_o = (state != IDLE).

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, next edge: drop cyc/stb, rsp_dat=ERR_DATA, rsp_err=1, rsp_valid=1, go to RESP.
  - Ack on the same edge as terminal count: ack wins (normal response, rsp_err=0).
- Not defined: no counter logic; BUS waits indefinitely for ack; rsp_err tied 0.

Test Plan:
- Write, adr=0x3000_0005, dat=0x0000_00A5, sel=0xF; slave acks after 2 wait cycles → wbm_adr_o=0x3000_0004, wbm_dat_o=0xA5, wbm_we_o=1, cyc/stb high exactly 3 cycles; rsp_valid with rsp_dat=0, rsp_err=0.
- Read, adr=0x3000_0000; zero-wait slave returns 0x1234_5678 → rsp_valid 2 cycles after handshake, rsp_dat=0x1234_5678, wbm_dat_o=0.
- rsp_ready held low 10 cycles after a read; cmd_valid held high with a new command throughout → rsp_valid/rsp_dat stable, cmd_ready=0 and no new cyc until the cycle after rsp_ready=1.
- Stray wbm_ack_i pulses in IDLE and RESP → no state change, rsp_dat unchanged, no cyc.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks → cyc high 4 cycles then low; rsp_err=1, rsp_dat=0xFFFF_FFFF. Repeat with ack on the terminal cycle → rsp_err=0, slave data returned.
- wb_rst_i asserted for 1 cycle mid-BUS and again in RESP → cyc/stb/rsp_valid 0 from that edge, cmd_ready=1; next command completes normally.
